sample_spi_tx: RTL and testbench

Output stage of the filter chain: captures each decimated filter word on its completion strobe and buffers it in a small FIFO. Serves the buffered words to the MCU over SPI, with the MCU as master and this block as slave, in SPI mode 0, MSB first, one word per chip-select frame. Asserts `data_ready` while words are waiting so the MCU can poll or use it as an interrupt line. `sdo` tri-stating is done at the top level, not here.

---
 rtl/barcode_pkg.sv | 14 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/sample_spi_tx.sv | 165 ++++++++++++++++
 tb/tb_sample_spi_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/barcode_pkg.sv
// Shared types and widths for the filter output stage.
package barcode_pkg;

    // Width of the decimated filter word; the SPI frame matches it.
    localparam int FIR_OUT_WIDTH = 32;

    // Serial transmit FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data.
// Full/empty come from the occupancy counter; pointers wrap modulo DEPTH.
// When full, a push is still accepted if a pop happens in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_spi_tx.sv
// Filter output stage: buffers decimated words and serves them to the MCU
// as an SPI mode-0 slave, MSB first, one word per chip-select frame.
module sample_spi_tx
    import barcode_pkg::*;
#(
    parameter int DATA_WIDTH  = FIR_OUT_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din_valid,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          sck,
    input  logic                          cs_n,
    output logic                          sdo,
    output logic                          data_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    // Handshake note: din_valid is a fire-and-forget strobe with no ready;
    // a word offered while the FIFO is full (and not popped that cycle) is
    // dropped and latched into the sticky overflow flag.

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic                   cs_prev;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    fsm_state_t             state;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [DATA_WIDTH-1:0]  cur_word;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   first;
    logic                   took_word;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_rdata;
    logic                   pop_req;
    logic                   push_acc;

    // Synchronisers for the asynchronous SPI pins. Reset to 0 so that a
    // cs_n already low when reset is released never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync <= '0;
            cs_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
        end
    end

    // Registered edge strobes from the synchronised pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_prev <= 1'b0;
            cs_prev  <= 1'b0;
            sck_fall <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
        end else begin
            sck_prev <= sck_sync[SYNC_STAGES-1];
            cs_prev  <= cs_sync[SYNC_STAGES-1];
            sck_fall <= sck_prev & ~sck_sync[SYNC_STAGES-1];
            cs_fall  <= cs_prev & ~cs_sync[SYNC_STAGES-1];
            cs_rise  <= ~cs_prev & cs_sync[SYNC_STAGES-1];
        end
    end

    assign pop_req  = (state == IDLE) && cs_fall && !fifo_empty;
    assign push_acc = din_valid && (!fifo_full || pop_req);

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (din_valid),
        .pop   (pop_req),
        .wdata (din),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The FIFO read is registered, so in the first SHIFT cycle the word sits
    // on fifo_rdata rather than in shreg; cur_word hides that one-cycle gap.
    always_comb begin
        cur_word = shreg;
        if (first) begin
            cur_word = took_word ? fifo_rdata : '0;
        end
    end

    assign sdo = (state == SHIFT) ? cur_word[DATA_WIDTH-1] : 1'b0;

    // Frame FSM, bit counter and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            first     <= 1'b0;
            took_word <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= SHIFT;
                        first     <= 1'b1;
                        took_word <= !fifo_empty;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    first <= 1'b0;
                    if (cs_rise) begin
                        state <= IDLE;
                    end else if (sck_fall) begin
                        shreg <= {cur_word[DATA_WIDTH-2:0], 1'b0};
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            state   <= DONE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        shreg <= cur_word;
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags: data_ready tracks next-cycle occupancy; overflow is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_ready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            data_ready <= push_acc || (fifo_count > CW'(pop_req));
            if (din_valid && fifo_full && !pop_req) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_spi_tx.sv
// Bench for sample_spi_tx: directed table, multi-cycle corner sequences and
// randomized push/frame traffic against a queue-based reference model.
module tb_sample_spi_tx;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         din_valid;
    logic [W-1:0] din;
    logic         sck;
    logic         cs_n;
    logic         sdo;
    logic         data_ready;
    logic         overflow;
    logic [2:0]   fifo_count;

    int checks = 0;
    int errors = 0;

    // Reference model: words waiting, and the sticky overflow flag.
    logic [W-1:0] exp_q[$];
    logic         m_overflow = 1'b0;

    typedef struct {
        logic [W-1:0] din;
        logic [2:0]   exp_count;
        logic         exp_ready;
        logic [W-1:0] exp_read;
    } vec_t;

    vec_t vecs[6];

    sample_spi_tx #(
        .DATA_WIDTH  (W),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .sck        (sck),
        .cs_n       (cs_n),
        .sdo        (sdo),
        .data_ready (data_ready),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [W-1:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else m_overflow = 1'b1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        @(negedge clk);
        din       = w;
        din_valid = 1'b1;
        model_push(w);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, W'(fifo_count), W'(exp_q.size()));
        check({tag, "_ready"}, W'(data_ready), W'(exp_q.size() != 0));
        check({tag, "_ovf"},   W'(overflow),   W'(m_overflow));
    endtask

    // One SPI master frame: cs_n low, nbits sck pulses at clk/8, cs_n high.
    // Optionally pulses din_valid in the cycle the DUT sees the cs_n fall.
    task automatic run_frame(input int nbits, input bit inject, input logic [W-1:0] inj_word,
                             output logic [W-1:0] rd, output logic [W-1:0] exp_word);
        @(negedge clk);
        cs_n     = 1'b0;
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (inject) begin
            repeat (SYNC + 1) @(negedge clk);
            din       = inj_word;
            din_valid = 1'b1;
            model_push(inj_word);
            @(negedge clk);
            din_valid = 1'b0;
            repeat (8 - SYNC - 2) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            rd  = {rd[W-2:0], sdo};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] ew;
        int           n;

        reset     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        sck       = 1'b0;
        cs_n      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sdo",   W'(sdo), '0);
        check("rst_ready", W'(data_ready), '0);
        check("rst_ovf",   W'(overflow), '0);
        check("rst_count", W'(fifo_count), '0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Frame on an empty FIFO sends zeros and leaves the flags alone.
        run_frame(W, 1'b0, '0, rd, ew);
        check("empty_frame", rd, 32'h0);
        check_status("empty");

        // Directed single push / single frame table.
        vecs[0] = '{32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{32'h00000000, 3'd1, 1'b1, 32'h00000000};
        vecs[2] = '{32'hFFFFFFFF, 3'd1, 1'b1, 32'hFFFFFFFF};
        vecs[3] = '{32'h80000001, 3'd1, 1'b1, 32'h80000001};
        vecs[4] = '{32'h12345678, 3'd1, 1'b1, 32'h12345678};
        vecs[5] = '{32'h5A5AA5A5, 3'd1, 1'b1, 32'h5A5AA5A5};
        for (int i = 0; i < 6; i++) begin
            push_word(vecs[i].din);
            check("tbl_ready", W'(data_ready), W'(vecs[i].exp_ready));
            check("tbl_count", W'(fifo_count), W'(vecs[i].exp_count));
            run_frame(W, 1'b0, '0, rd, ew);
            check("tbl_read", rd, vecs[i].exp_read);
            check("tbl_model", rd, ew);
            check_status("tbl_after");
        end

        // Push coinciding with the pop of a non-empty FIFO.
        push_word(32'h12345678);
        run_frame(W, 1'b1, 32'hAAAA5555, rd, ew);
        check("coinc_first", rd, 32'h12345678);
        run_frame(W, 1'b0, '0, rd, ew);
        check("coinc_second", rd, 32'hAAAA5555);

        // Push coinciding with the pop of an empty FIFO: no bypass.
        run_frame(W, 1'b1, 32'hC0FFEE11, rd, ew);
        check("bypass_zero", rd, 32'h0);
        check_status("bypass");
        run_frame(W, 1'b0, '0, rd, ew);
        check("bypass_next", rd, 32'hC0FFEE11);

        // Aborted frame after 10 bits loses its word.
        push_word(32'hF00DCAFE);
        push_word(32'h0BADF00D);
        run_frame(10, 1'b0, '0, rd, ew);
        check("abort_bits", rd, W'(32'hF00DCAFE >> (W - 10)));
        check_status("abort");
        run_frame(W, 1'b0, '0, rd, ew);
        check("abort_next", rd, 32'h0BADF00D);

        // Overflow: five pushes into a depth-4 FIFO.
        for (int i = 1; i <= 5; i++) push_word(W'(i));
        check("ovf_flag",  W'(overflow), 32'h1);
        check("ovf_count", W'(fifo_count), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            run_frame(W, 1'b0, '0, rd, ew);
            check("ovf_read", rd, W'(i));
        end
        check_status("ovf_drain");

        // Randomized traffic against the model.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) push_word($urandom);
            check_status("rnd_push");
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) run_frame(W, 1'b1, $urandom, rd, ew);
                else run_frame(W, 1'b0, '0, rd, ew);
                check("rnd_read", rd, ew);
            end
            check_status("rnd_frames");
        end

        // Reset during bit 16 with cs_n held low afterwards.
        push_word(32'h89ABCDEF);
        @(negedge clk);
        cs_n = 1'b0;
        void'(exp_q.pop_front());
        repeat (8) @(negedge clk);
        rd = '0;
        for (int i = 0; i < 16; i++) begin
            rd  = {rd[W-2:0], sdo};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("pre_rst_bits", rd, W'(32'h89ABCDEF >> 16));
        sck   = 1'b1;
        reset = 1'b0;
        exp_q.delete();
        m_overflow = 1'b0;
        @(negedge clk);
        check("mid_rst_sdo", W'(sdo), '0);
        sck = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("post_rst_sdo", W'(sdo), '0);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            check("post_rst_sdo_hi", W'(sdo), '0);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        check_status("post_rst");
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        run_frame(W, 1'b0, '0, rd, ew);
        check("post_rst_frame", rd, 32'h0);
        check_status("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
